// File: rtl/seq_divider_16by8_pkg.sv
// Shared definitions for the sequential 16-by-8 restoring divider.
package seq_divider_16by8_pkg;

    // Default dividend/quotient and divisor/remainder widths
    localparam int unsigned DefN = 16;
    localparam int unsigned DefM = 8;

    // Control FSM encoding
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_divider_16by8_if.sv
// Start/Done handshake, operand and result bundle for the divider.
interface seq_divider_16by8_if
    import seq_divider_16by8_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned M = DefM
) ();

    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_zero;

    // Requester side: drives operands and start, observes results
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/seq_divider_16by8_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module seq_divider_16by8_div_step
    import seq_divider_16by8_pkg::*;
#(
    parameter int unsigned M = DefM
) (
    input  logic [M-1:0] p_i,
    input  logic         q_msb_i,
    input  logic [M-1:0] d_i,
    output logic [M-1:0] p_next_o,
    output logic         q_bit_o
);

    logic [M:0] t;

    // Trial subtraction; the M-bit difference is exact because the result is < d
    always_comb begin
        t        = {p_i, q_msb_i};
        q_bit_o  = (t >= {1'b0, d_i});
        p_next_o = q_bit_o ? (t[M-1:0] - d_i) : t[M-1:0];
    end

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module seq_divider_16by8
    import seq_divider_16by8_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned M = DefM
) (
    input logic                clk_i,
    input logic                rst_i,
    seq_divider_16by8_if.slave bus
);

    localparam int unsigned CntW = $clog2(N);

    state_e        state_q, state_d;
    logic [CntW-1:0] cnt_q;
    // Partial remainder: its top bit only ever lives in T, so only M bits are stored
    logic [M-1:0]  p_q;
    logic [N-1:0]  q_q;
    logic [M-1:0]  d_q;
    logic [N-1:0]  quo_q;
    logic [M-1:0]  rem_q;
    logic          dz_q;
    logic          done_q;

    logic          last_iter;
    logic [M-1:0]  p_next;
    logic          q_bit;

    assign last_iter = (cnt_q == CntW'(N - 1));

    seq_divider_16by8_div_step #(
        .M (M)
    ) u_div_step (
        .p_i      (p_q),
        .q_msb_i  (q_q[N-1]),
        .d_i      (d_q),
        .p_next_o (p_next),
        .q_bit_o  (q_bit)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero divisor is answered from IDLE without entering RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start && (bus.divisor != '0)) state_d = StRun;
            StRun:  if (last_iter) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: all come straight from registers
    always_comb begin
        bus.busy      = (state_q == StRun);
        bus.done      = done_q;
        bus.quotient  = quo_q;
        bus.remainder = rem_q;
        bus.div_zero  = dz_q;
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            p_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quo_q  <= '1;
                            rem_q  <= '1;
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            d_q   <= bus.divisor;
                            q_q   <= bus.dividend;
                            p_q   <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                StRun: begin
                    p_q   <= p_next;
                    q_q   <= {q_q[N-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        quo_q  <= {q_q[N-2:0], q_bit};
                        rem_q  <= p_next;
                        dz_q   <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Scoreboard-based bench for the sequential 16-by-8 divider.
module tb_seq_divider_16by8;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    res_t sb[$];

    seq_divider_16by8_if bus ();

    seq_divider_16by8 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
        res_t r;
        if (b == 8'd0) begin
            r.q  = 16'hFFFF;
            r.r  = 8'hFF;
            r.dz = 1'b1;
        end else begin
            r.q  = a / {8'd0, b};
            r.r  = 8'(a % {8'd0, b});
            r.dz = 1'b0;
        end
        return r;
    endfunction

    // Drive a one-cycle start; returns at the negedge after the accepting edge
    task automatic start_op(input logic [15:0] a, input logic [7:0] b, input bit expect_done);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (expect_done) sb.push_back(model(a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Bounded wait for done; counts negedges waited and busy-high samples seen
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!bus.done && cycles < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic [25:0] got;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got = {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (got !== 26'd0) $display("FAIL reset_state: got %h want 0", got);
        else passed++;
    endtask

    task automatic test_basic();
        int   cyc, bcnt;
        res_t got, exp;
        start_op(16'd100, 8'd7, 1'b1);
        wait_done(cyc, bcnt);
        checks++;
        if (cyc !== 16) $display("FAIL basic_latency: got %0d want 16", cyc);
        else passed++;
        checks++;
        if (bcnt !== 16) $display("FAIL basic_busy_cycles: got %0d want 16", bcnt);
        else passed++;
        got = {bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (got !== {16'd14, 8'd2, 1'b0}) $display("FAIL basic_const: got %h want 14/2/0", got);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL basic_sb: unexpected done, got %h", got);
        else begin
            exp = sb.pop_front();
            if (got !== exp) $display("FAIL basic_sb: got %h want %h", got, exp);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", bus.done);
        else passed++;
    endtask

    task automatic test_extremes();
        logic [15:0] as[3] = '{16'hFFFF, 16'd0, 16'h00FE};
        logic [7:0]  bs[3] = '{8'hFF, 8'd5, 8'hFF};
        res_t        want[3] = '{{16'h0101, 8'h00, 1'b0}, {16'h0000, 8'h00, 1'b0},
                                 {16'h0000, 8'hFE, 1'b0}};
        int          cyc, bcnt;
        res_t        got, exp;
        for (int i = 0; i < 3; i++) begin
            start_op(as[i], bs[i], 1'b1);
            wait_done(cyc, bcnt);
            got = {bus.quotient, bus.remainder, bus.div_zero};
            checks++;
            if (got !== want[i]) $display("FAIL extreme_%0d: got %h want %h", i, got, want[i]);
            else passed++;
            checks++;
            if (sb.size() == 0) $display("FAIL extreme_sb_%0d: unexpected done", i);
            else begin
                exp = sb.pop_front();
                if (got !== exp) $display("FAIL extreme_sb_%0d: got %h want %h", i, got, exp);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        int   cyc, bcnt;
        res_t got, exp;
        start_op(16'd1234, 8'd0, 1'b1);
        wait_done(cyc, bcnt);
        checks++;
        if (cyc !== 0 || bcnt !== 0)
            $display("FAIL divzero_latency: got wait %0d busy %0d want 0/0", cyc, bcnt);
        else passed++;
        got = {bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (sb.size() == 0) $display("FAIL divzero_sb: unexpected done, got %h", got);
        else begin
            exp = sb.pop_front();
            if (got !== exp) $display("FAIL divzero_sb: got %h want %h", got, exp);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.div_zero !== 1'b1)
            $display("FAIL divzero_hold: got done %b busy %b dz %b want 0 0 1",
                     bus.done, bus.busy, bus.div_zero);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int          cyc, bcnt;
        int          seen_done;
        logic [25:0] st;
        res_t        got, exp;
        start_op(16'd5000, 8'd3, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        st = {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (st !== 26'd0) $display("FAIL midrun_reset: got %h want 0", st);
        else passed++;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) $display("FAIL midrun_no_done: got %0d dones want 0", seen_done);
        else passed++;
        // Reset and a divide-by-zero start in the same cycle: reset must win
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 16'd1234;
        bus.divisor  = 8'd0;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.quotient !== 16'd0)
            $display("FAIL reset_beats_start: got done %b dz %b q %h want 0 0 0",
                     bus.done, bus.div_zero, bus.quotient);
        else passed++;
        start_op(16'd5000, 8'd3, 1'b1);
        wait_done(cyc, bcnt);
        got = {bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (got !== {16'd1666, 8'd2, 1'b0}) $display("FAIL midrun_restart: got %h want 1666/2", got);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL midrun_sb: unexpected done, got %h", got);
        else begin
            exp = sb.pop_front();
            if (got !== exp) $display("FAIL midrun_sb: got %h want %h", got, exp);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_handshake();
        int   cyc, bcnt, extra;
        res_t got, exp;
        start_op(16'd50000, 8'd123, 1'b1);
        // Scramble operands and pulse start while busy
        for (int i = 0; i < 3; i++) begin
            bus.dividend = 16'(i * 777 + 5);
            bus.divisor  = 8'(i);
            bus.start    = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            @(negedge clk);
        end
        wait_done(cyc, bcnt);
        got = {bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (sb.size() == 0) $display("FAIL handshake_sb: unexpected done, got %h", got);
        else begin
            exp = sb.pop_front();
            if (got !== exp) $display("FAIL handshake_sb: got %h want %h", got, exp);
            else passed++;
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL handshake_ignored: got %0d busy/done samples want 0", extra);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int   cyc, bcnt;
        res_t got, exp;
        start_op(16'd1000, 8'd7, 1'b1);
        wait_done(cyc, bcnt);
        got = {bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (sb.size() == 0) $display("FAIL b2b_first_sb: unexpected done, got %h", got);
        else begin
            exp = sb.pop_front();
            if (got !== exp) $display("FAIL b2b_first_sb: got %h want %h", got, exp);
            else passed++;
        end
        // Start presented in the Done cycle
        start_op(16'd200, 8'd9, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL b2b_busy: got busy %b done %b want 1 0", bus.busy, bus.done);
        else passed++;
        wait_done(cyc, bcnt);
        got = {bus.quotient, bus.remainder, bus.div_zero};
        checks++;
        if (got !== {16'd22, 8'd2, 1'b0} || cyc !== 16)
            $display("FAIL b2b_second: got %h after %0d want 22/2 after 16", got, cyc);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL b2b_second_sb: unexpected done, got %h", got);
        else begin
            exp = sb.pop_front();
            if (got !== exp) $display("FAIL b2b_second_sb: got %h want %h", got, exp);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int          cyc, bcnt, bad_sb, bad_id;
        logic [15:0] a;
        logic [7:0]  b;
        res_t        got, exp;
        bad_sb = 0;
        bad_id = 0;
        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            start_op(a, b, 1'b1);
            wait_done(cyc, bcnt);
            got = {bus.quotient, bus.remainder, bus.div_zero};
            if (sb.size() == 0) begin
                bad_sb++;
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad_sb++;
                    if (bad_sb < 5) $display("FAIL random_sb %0d/%0d: got %h want %h", a, b, got, exp);
                end
            end
            if (b != 8'd0) begin
                if ((int'(bus.quotient) * int'(b) + int'(bus.remainder)) != int'(a)
                    || bus.remainder >= b) begin
                    bad_id++;
                    if (bad_id < 5) $display("FAIL random_identity %0d/%0d: q %0d r %0d",
                                             a, b, bus.quotient, bus.remainder);
                end
            end
        end
        checks++;
        if (bad_sb !== 0) $display("FAIL random_scoreboard: got %0d errors want 0", bad_sb);
        else passed++;
        checks++;
        if (bad_id !== 0) $display("FAIL random_identity_total: got %0d errors want 0", bad_id);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_reset_mid_run();
        test_handshake();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
